nibble_serial_subtractor: RTL and testbench

- Iterative multi-word subtractor: computes a - b - bin over WIDTH-bit operands, one 4-bit nibble per clock, LSB nibble first.
- Ripple-borrow logic per nibble; borrow is carried in a register between cycles.
- Sits beside the team's 4-bit carry adder as the arithmetic datapath's subtract/compare unit.
- Valid/ready handshake on input and output.

---
 rtl/nibble_serial_subtractor_if.sv | 50 +++++
 rtl/nibble_serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and data bundle for the nibble-serial subtractor.
// The source/consumer side uses the master modport and the subtractor uses slave.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
) ();

  // Operand side: the source presents a, b and bin with in_valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;

  // Result side: the result is held with out_valid until out_ready.
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output bin,
    input  out_valid,
    output out_ready,
    input  diff,
    input  bout,
    input  ovf,
    input  zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  bin,
    output out_valid,
    input  out_ready,
    output diff,
    output bout,
    output ovf,
    output zero
  );

endinterface

// File: rtl/nibble_serial_subtractor.sv
// Iterative subtractor: diff = a - b - bin over WIDTH bits, one nibble per clock,
// least significant nibble first, with the borrow carried between cycles in a register.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  nibble_serial_subtractor_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_next;
  logic             borrow_reg;
  logic             br_out;
  logic [CW-1:0]    cnt;
  logic             bout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic [3:0] x_nib;
  logic [3:0] y_nib;
  logic [3:0] d_nib;
  logic       accept;
  logic       last_nib;

  // The final nibble is the one whose index is NIB-1; with WIDTH=4 that is the only one.
  assign last_nib = (cnt == CW'(NIB - 1));

  // Handshake flags come straight from the state so they never glitch with the data.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

  // Select the operand nibbles addressed by the nibble counter.
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        x_nib = a_reg[4*k +: 4];
        y_nib = b_reg[4*k +: 4];
      end
    end
  end

  // Four-bit ripple-borrow subtract of the current nibble, seeded by the stored borrow.
  always_comb begin : ripple
    logic br;
    br    = borrow_reg;
    d_nib = '0;
    for (int i = 0; i < 4; i++) begin
      d_nib[i] = x_nib[i] ^ y_nib[i] ^ br;
      br       = (~x_nib[i] & y_nib[i]) | (~(x_nib[i] ^ y_nib[i]) & br);
    end
    br_out = br;
  end

  // Merge the freshly computed nibble into the partial difference so the last cycle
  // can derive zero and overflow from the complete result.
  always_comb begin
    diff_next = diff_reg;
    for (int k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        diff_next[4*k +: 4] = d_nib;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold the result in DONE until taken.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, step one nibble per RUN cycle, and latch the
  // flags on the last nibble. The result registers only change in RUN, so they hold
  // steady for as long as the consumer stalls in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      cnt        <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (accept) begin
      a_reg      <= bus.a;
      b_reg      <= bus.b;
      borrow_reg <= bus.bin;
      cnt        <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (state == RUN) begin
      diff_reg   <= diff_next;
      borrow_reg <= br_out;
      if (last_nib) begin
        cnt      <= '0;
        bout_reg <= br_out;
        ovf_reg  <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (a_reg[WIDTH-1] ^ diff_next[WIDTH-1]);
        zero_reg <= (diff_next == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor at WIDTH=16 and WIDTH=4:
// directed vector table, backpressure and mid-run reset sequences, then random ops
// against an arithmetic reference.
module tb_nibble_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.WIDTH(16)) if16 ();
  nibble_serial_subtractor_if #(.WIDTH(4))  if4 ();

  nibble_serial_subtractor #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  nibble_serial_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[13];

  int checkCount = 0;
  int passCount  = 0;

  logic [15:0] gotDiff;
  logic        gotBout;
  logic        gotOvf;
  logic        gotZero;
  int          gotLat;
  bit          gotTimeout;

  // Record one comparison and report it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference result from plain wide subtraction: {diff, bout, ovf, zero}.
  function automatic logic [18:0] model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    logic [16:0] r16;
    logic [4:0]  r4;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    if (w == 16) begin
      r16 = {1'b0, av} - {1'b0, bv} - 17'(bi);
      d   = r16[15:0];
      bo  = r16[16];
      ov  = (av[15] ^ bv[15]) & (av[15] ^ d[15]);
    end else begin
      r4 = {1'b0, av[3:0]} - {1'b0, bv[3:0]} - 5'(bi);
      d  = {12'h000, r4[3:0]};
      bo = r4[4];
      ov = (av[3] ^ bv[3]) & (av[3] ^ d[3]);
    end
    return {d, bo, ov, (d == 16'h0000)};
  endfunction

  function automatic logic readyOf(input int w);
    return (w == 16) ? if16.in_ready : if4.in_ready;
  endfunction

  task automatic driveInputs(input int w, input logic valid, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    if (w == 16) begin
      if16.in_valid = valid;
      if16.a        = av;
      if16.b        = bv;
      if16.bin      = bi;
    end else begin
      if4.in_valid = valid;
      if4.a        = av[3:0];
      if4.b        = bv[3:0];
      if4.bin      = bi;
    end
  endtask

  // Offer one operation, wait for its acceptance, scramble the operand inputs, then
  // count clock edges until out_valid rises and capture the result.
  task automatic applyStimulus(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int   guard;
    logic seen;
    @(negedge clk);
    driveInputs(w, 1'b1, av, bv, bi);
    guard = 0;
    while (!readyOf(w) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    driveInputs(w, 1'b0, ~av, ~bv, ~bi);
    gotLat = 0;
    seen   = 1'b0;
    while (!seen && gotLat < 20) begin
      @(posedge clk);
      #1;
      gotLat++;
      seen = (w == 16) ? if16.out_valid : if4.out_valid;
    end
    gotTimeout = !seen;
    if (gotTimeout) begin
      checkCount++;
      $display("[TB] FAIL timeout: out_valid still 0 after 20 cycles, expected 1 after %0d", w / 4);
    end
    gotDiff = (w == 16) ? if16.diff : {12'h000, if4.diff};
    gotBout = (w == 16) ? if16.bout : if4.bout;
    gotOvf  = (w == 16) ? if16.ovf  : if4.ovf;
    gotZero = (w == 16) ? if16.zero : if4.zero;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbi;

    vecs[0]  = '{16, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{16, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4,  16'h0003, 16'h0005, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4,  16'h0008, 16'h0001, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4,  16'h0007, 16'h000F, 1'b0, 16'h0008, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{4,  16'h0006, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{4,  16'h000F, 16'h000E, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

    // Reset state of both widths.
    rst = 1'b1;
    driveInputs(16, 1'b0, 16'h0000, 16'h0000, 1'b0);
    driveInputs(4, 1'b0, 16'h0000, 16'h0000, 1'b0);
    if16.out_ready = 1'b1;
    if4.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset16", {if16.in_ready, if16.out_valid, if16.diff, if16.bout, if16.ovf, if16.zero},
                {1'b1, 1'b0, 16'h0000, 3'b000});
    checkOutput("reset4", {if4.in_ready, if4.out_valid, if4.diff, if4.bout, if4.ovf, if4.zero},
                {1'b1, 1'b0, 4'h0, 3'b000});
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results and the expected latency.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].bin);
      if (!gotTimeout) begin
        checkOutput($sformatf("vec%0d latency", i), 32'(gotLat), 32'(vecs[i].w / 4));
        checkOutput($sformatf("vec%0d result", i), {gotDiff, gotBout, gotOvf, gotZero},
                    {vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero});
      end
    end

    // Backpressure: hold the result for 10 cycles while in_valid pulses are ignored.
    @(negedge clk);
    if16.out_ready = 1'b0;
    applyStimulus(16, 16'h1234, 16'h0234, 1'b0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if16.in_valid = cyc[0];
      if16.a        = 16'hFFFF;
      if16.b        = 16'h0001;
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d", cyc),
                  {if16.out_valid, if16.in_ready, if16.diff, if16.bout, if16.ovf, if16.zero},
                  {1'b1, 1'b0, 16'h1000, 3'b000});
    end
    @(negedge clk);
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release", {if16.out_valid, if16.in_ready}, 2'b01);
    @(posedge clk);
    #1;
    checkOutput("idle after release", {if16.out_valid, if16.in_ready}, 2'b01);

    // Reset during the second RUN cycle discards the partial result.
    @(negedge clk);
    driveInputs(16, 1'b1, 16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    driveInputs(16, 1'b0, 16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset mid-run",
                {if16.in_ready, if16.out_valid, if16.diff, if16.bout, if16.ovf, if16.zero},
                {1'b1, 1'b0, 16'h0000, 3'b000});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("no resume after reset", {if16.in_ready, if16.out_valid}, 2'b10);
    applyStimulus(16, 16'h4321, 16'h1234, 1'b0);
    if (!gotTimeout) begin
      checkOutput("post-reset latency", 32'(gotLat), 32'd4);
      checkOutput("post-reset result", {gotDiff, gotBout, gotOvf, gotZero}, {16'h30ED, 3'b000});
    end

    // Random back-to-back operations with out_ready held high.
    for (int wsel = 0; wsel < 2; wsel++) begin
      for (int n = 0; n < 1000; n++) begin
        int w;
        w   = (wsel == 0) ? 16 : 4;
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rbi = 1'($urandom);
        applyStimulus(w, ra, rb, rbi);
        if (!gotTimeout) begin
          checkOutput($sformatf("rand w%0d #%0d a=%h b=%h bin=%0d", w, n, ra, rb, rbi),
                      {gotDiff, gotBout, gotOvf, gotZero}, model(w, ra, rb, rbi));
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
